wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the single-cycle pipeline and a buffered multi-cycle unit.
// Latency: one cycle from the winning request to reg_write_en_o/rd_label_o/wr_data_o.
// Backpressure: the pipeline is never stalled; the MDU is held off via mdu_ready_o when the buffer is full.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_valid_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    output logic        reg_write_en_o,
    output logic [4:0]  rd_label_o,
    output logic [31:0] wr_data_o,
    output logic [31:0] pending_mask_o,
    output logic        drain_req_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [2:0]    AGE_LIMIT = 3'(STARVE_LIMIT);

    logic [4:0]       ent_rd   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_kill;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic [2:0]       age;

    logic pipe_req;
    logic push;
    logic empty;
    logic head_kill;
    logic pop;
    logic head_wr;
    logic bypass;
    logic alloc;

    // Per-cycle arbitration decisions, all derived from registered buffer state plus this cycle's requests.
    always_comb begin
        pipe_req    = pipe_valid_i && (pipe_rd_i != 5'd0);
        mdu_ready_o = (count < FULL_CNT);
        push        = mdu_valid_i && mdu_ready_o;
        empty       = (count == '0);
        head_kill   = ent_kill[rptr];
        // A killed head leaves regardless of the pipe; a live head leaves only when it wins the port.
        pop         = !empty && (head_kill || !pipe_req);
        head_wr     = !empty && !head_kill && !pipe_req;
        bypass      = !pipe_req && empty && push && (mdu_rd_i != 5'd0);
        // x0 results and results already overwritten by a same-cycle pipe write are swallowed.
        alloc       = push && (mdu_rd_i != 5'd0)
                      && !(pipe_req && (mdu_rd_i == pipe_rd_i)) && !bypass;
    end

    // Scoreboard of registers with a live buffered write outstanding.
    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !ent_kill[i]) begin
                pending_mask_o[ent_rd[i]] = 1'b1;
            end
        end
    end

    assign drain_req_o = (age >= AGE_LIMIT);

    // Entry payload storage; validity is tracked separately so payload needs no reset.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            ent_rd[wptr]   <= mdu_rd_i;
            ent_data[wptr] <= mdu_data_i;
        end
    end

    // Buffer control: squash, pop, push and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_vld  <= '0;
            ent_kill <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            // A newer pipe write to the same register makes the buffered result stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_req && ent_vld[i] && (ent_rd[i] == pipe_rd_i)) begin
                    ent_kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                ent_vld[rptr]  <= 1'b0;
                ent_kill[rptr] <= 1'b0;
                rptr           <= rptr + AW'(1);
            end
            if (alloc) begin
                ent_vld[wptr]  <= 1'b1;
                ent_kill[wptr] <= 1'b0;
                wptr           <= wptr + AW'(1);
            end
            if (alloc && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !alloc) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head-age counter: how long a live head has been denied the port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age <= 3'd0;
        end else if (pop || empty) begin
            age <= 3'd0;
        end else if (!head_kill && (age != 3'd7)) begin
            age <= age + 3'd1;
        end
    end

    // Registered write port: pipe first, then the buffer head, then an MDU bypass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_write_en_o <= 1'b0;
            rd_label_o     <= 5'd0;
            wr_data_o      <= 32'd0;
        end else if (pipe_req) begin
            reg_write_en_o <= 1'b1;
            rd_label_o     <= pipe_rd_i;
            wr_data_o      <= pipe_data_i;
        end else if (head_wr) begin
            reg_write_en_o <= 1'b1;
            rd_label_o     <= ent_rd[rptr];
            wr_data_o      <= ent_data[rptr];
        end else if (bypass) begin
            reg_write_en_o <= 1'b1;
            rd_label_o     <= mdu_rd_i;
            wr_data_o      <= mdu_data_i;
        end else begin
            reg_write_en_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Outputs are sampled 1 time unit after each rising clock edge.
// The model tracks buffered MDU results as an ordered list with a stale flag.
module tb_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        reg_write_en_o;
    logic [4:0]  rd_label_o;
    logic [31:0] wr_data_o;
    logic [31:0] pending_mask_o;
    logic        drain_req_o;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pipe_valid_i   (pipe_valid_i),
        .pipe_rd_i      (pipe_rd_i),
        .pipe_data_i    (pipe_data_i),
        .mdu_valid_i    (mdu_valid_i),
        .mdu_rd_i       (mdu_rd_i),
        .mdu_data_i     (mdu_data_i),
        .mdu_ready_o    (mdu_ready_o),
        .reg_write_en_o (reg_write_en_o),
        .rd_label_o     (rd_label_o),
        .wr_data_o      (wr_data_o),
        .pending_mask_o (pending_mask_o),
        .drain_req_o    (drain_req_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t        mq[$];
    bit          m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_age;

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (!mq[i].killed) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_drain();
        return m_age >= STARVE_LIMIT;
    endfunction

    function automatic void m_clear();
        mq.delete();
        m_en   = 1'b0;
        m_rd   = 5'd0;
        m_data = 32'd0;
        m_age  = 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and step past the edge.
    task automatic tick(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        bit push, preq, hk, pop;
        int sz, new_age;
        ent_t e;
        pipe_valid_i = pv;
        pipe_rd_i    = prd;
        pipe_data_i  = pd;
        mdu_valid_i  = mv;
        mdu_rd_i     = mrd;
        mdu_data_i   = md;

        sz   = mq.size();
        push = mv && (sz < DEPTH);
        preq = pv && (prd != 5'd0);
        hk   = (sz > 0) && mq[0].killed;

        m_en = 1'b0;
        if (preq) begin
            m_en = 1'b1; m_rd = prd; m_data = pd;
        end else if (sz > 0 && !hk) begin
            m_en = 1'b1; m_rd = mq[0].rd; m_data = mq[0].data;
        end else if (sz == 0 && push && mrd != 5'd0) begin
            m_en = 1'b1; m_rd = mrd; m_data = md;
        end

        pop = (sz > 0) && (hk || !preq);
        if (pop || sz == 0) new_age = 0;
        else if (!mq[0].killed) new_age = (m_age < 7) ? m_age + 1 : 7;
        else new_age = m_age;

        if (preq) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].rd == prd) begin
                    e = mq[i]; e.killed = 1'b1; mq[i] = e;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push && mrd != 5'd0 && !(preq && mrd == prd) && !(!preq && sz == 0)) begin
            e.rd = mrd; e.data = md; e.killed = 1'b0;
            mq.push_back(e);
        end
        m_age = new_age;

        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        tick(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd4; pipe_data_i = 32'hDEAD;
        mdu_valid_i  = 1'b1; mdu_rd_i  = 5'd6; mdu_data_i  = 32'hBEEF;
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || rd_label_o !== 5'd0 || wr_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b rd=%0d data=%h, want en=0 rd=0 data=0",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        n_cmp++;
        if (pending_mask_o !== 32'd0 || drain_req_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: got mask=%h drain=%b ready=%b, want mask=0 drain=0 ready=1",
                     pending_mask_o, drain_req_o, mdu_ready_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held: got en=%b mask=%h, want en=0 mask=0", reg_write_en_o, pending_mask_o);
        end
        pipe_valid_i = 1'b0; mdu_valid_i = 1'b0;
        rst_i = 1'b0;
        m_clear();
        idle();
    endtask

    task automatic test_bypass();
        tick(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd5 || wr_data_o !== 32'h1234) begin
            n_fail++;
            $display("FAIL bypass_write: got en=%b rd=%0d data=%h, want en=1 rd=5 data=1234",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        n_cmp++;
        if (pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_no_alloc: got mask=%h ready=%b, want mask=0 ready=1",
                     pending_mask_o, mdu_ready_o);
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_single: got en=%b, want en=0", reg_write_en_o);
        end
        // Pipe write to x0 leaves the port free for an MDU bypass.
        tick(1, 5'd0, 32'h99, 1, 5'd8, 32'h88);
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd8 || wr_data_o !== 32'h88) begin
            n_fail++;
            $display("FAIL pipe_x0_ignored: got en=%b rd=%0d data=%h, want en=1 rd=8 data=88",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        // MDU result to x0 is accepted but produces nothing.
        tick(0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mdu_x0_dropped: got en=%b mask=%h, want en=0 mask=0", reg_write_en_o, pending_mask_o);
        end
    endtask

    task automatic test_collision();
        tick(1, 5'd3, 32'hA, 1, 5'd7, 32'hB);
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd3 || wr_data_o !== 32'hA) begin
            n_fail++;
            $display("FAIL collision_pipe: got en=%b rd=%0d data=%h, want en=1 rd=3 data=a",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        n_cmp++;
        if (pending_mask_o !== 32'h80) begin
            n_fail++;
            $display("FAIL collision_pending: got mask=%h, want mask=00000080", pending_mask_o);
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd7 || wr_data_o !== 32'hB || pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL collision_mdu: got en=%b rd=%0d data=%h mask=%h, want en=1 rd=7 data=b mask=0",
                     reg_write_en_o, rd_label_o, wr_data_o, pending_mask_o);
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_done: got en=%b, want en=0", reg_write_en_o);
        end
    endtask

    task automatic test_full();
        tick(1, 5'd1, 32'hA1, 1, 5'd10, 32'hD10);
        n_cmp++;
        if (mdu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_one_entry: got ready=%b, want ready=1", mdu_ready_o);
        end
        tick(1, 5'd2, 32'hA2, 1, 5'd11, 32'hD11);
        n_cmp++;
        if (mdu_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready_low: got ready=%b, want ready=0", mdu_ready_o);
        end
        tick(1, 5'd3, 32'hA3, 1, 5'd12, 32'hD12);
        n_cmp++;
        if (mdu_ready_o !== 1'b0 || pending_mask_o !== 32'h0C00 || rd_label_o !== 5'd3) begin
            n_fail++;
            $display("FAIL full_held_off: got ready=%b mask=%h rd=%0d, want ready=0 mask=00000c00 rd=3",
                     mdu_ready_o, pending_mask_o, rd_label_o);
        end
        tick(0, 5'd0, 32'd0, 1, 5'd12, 32'hD12);
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd10 || wr_data_o !== 32'hD10 || mdu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain_first: got en=%b rd=%0d data=%h ready=%b, want en=1 rd=10 data=d10 ready=1",
                     reg_write_en_o, rd_label_o, wr_data_o, mdu_ready_o);
        end
        tick(0, 5'd0, 32'd0, 1, 5'd12, 32'hD12);
        n_cmp++;
        if (rd_label_o !== 5'd11 || wr_data_o !== 32'hD11 || pending_mask_o !== 32'h1000) begin
            n_fail++;
            $display("FAIL full_drain_second: got rd=%0d data=%h mask=%h, want rd=11 data=d11 mask=00001000",
                     rd_label_o, wr_data_o, pending_mask_o);
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd12 || wr_data_o !== 32'hD12) begin
            n_fail++;
            $display("FAIL full_third: got en=%b rd=%0d data=%h, want en=1 rd=12 data=d12",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        idle();
    endtask

    task automatic test_starvation();
        tick(1, 5'd1, 32'h1, 1, 5'd20, 32'h2020);
        for (int k = 1; k <= 4; k++) begin
            tick(1, 5'(k + 1), 32'(k), 0, 5'd0, 32'd0);
            n_cmp++;
            if (drain_req_o !== (k == 4)) begin
                n_fail++;
                $display("FAIL starve_wait%0d: got drain=%b, want drain=%b", k, drain_req_o, (k == 4));
            end
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd20 || wr_data_o !== 32'h2020 || drain_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_release: got en=%b rd=%0d data=%h drain=%b, want en=1 rd=20 data=2020 drain=0",
                     reg_write_en_o, rd_label_o, wr_data_o, drain_req_o);
        end
        idle();
    endtask

    task automatic test_waw();
        tick(1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
        n_cmp++;
        if (pending_mask_o !== 32'h200) begin
            n_fail++;
            $display("FAIL waw_pending: got mask=%h, want mask=00000200", pending_mask_o);
        end
        tick(1, 5'd9, 32'h55, 0, 5'd0, 32'd0);
        n_cmp++;
        if (reg_write_en_o !== 1'b1 || rd_label_o !== 5'd9 || wr_data_o !== 32'h55 || pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL waw_pipe: got en=%b rd=%0d data=%h mask=%h, want en=1 rd=9 data=55 mask=0",
                     reg_write_en_o, rd_label_o, wr_data_o, pending_mask_o);
        end
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_squashed: got en=%b ready=%b, want en=0 ready=1", reg_write_en_o, mdu_ready_o);
        end
        // Same-cycle MDU result to the register the pipe is writing is discarded.
        tick(1, 5'd6, 32'h66, 1, 5'd6, 32'h77);
        idle();
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || pending_mask_o !== 32'd0) begin
            n_fail++;
            $display("FAIL waw_same_cycle: got en=%b mask=%h, want en=0 mask=0", reg_write_en_o, pending_mask_o);
        end
    endtask

    task automatic test_random();
        int busy;
        for (int c = 0; c < 600; c++) begin
            if (c % 25 == 0) busy = (c % 75 == 0) ? 10 : ((c % 75 == 25) ? 50 : 95);
            tick($urandom_range(99) < busy, 5'($urandom_range(7)), $urandom,
                 $urandom_range(1), 5'($urandom_range(7)), $urandom);
            n_cmp++;
            if (reg_write_en_o !== m_en || (m_en && (rd_label_o !== m_rd || wr_data_o !== m_data))) begin
                n_fail++;
                $display("FAIL rand_write c=%0d: got en=%b rd=%0d data=%h, want en=%b rd=%0d data=%h",
                         c, reg_write_en_o, rd_label_o, wr_data_o, m_en, m_rd, m_data);
            end
            n_cmp++;
            if (mdu_ready_o !== m_ready() || pending_mask_o !== m_mask() || drain_req_o !== m_drain()) begin
                n_fail++;
                $display("FAIL rand_status c=%0d: got ready=%b mask=%h drain=%b, want ready=%b mask=%h drain=%b",
                         c, mdu_ready_o, pending_mask_o, drain_req_o, m_ready(), m_mask(), m_drain());
            end
        end
        repeat (6) idle();
        n_cmp++;
        if (pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1 || reg_write_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drained: got mask=%h ready=%b en=%b, want mask=0 ready=1 en=0",
                     pending_mask_o, mdu_ready_o, reg_write_en_o);
        end
    endtask

    task automatic test_mid_reset();
        tick(1, 5'd1, 32'h1, 1, 5'd13, 32'h13);
        tick(1, 5'd2, 32'h2, 1, 5'd14, 32'h14);
        pipe_valid_i = 1'b0; mdu_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (reg_write_en_o !== 1'b0 || rd_label_o !== 5'd0 || wr_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got en=%b rd=%0d data=%h, want en=0 rd=0 data=0",
                     reg_write_en_o, rd_label_o, wr_data_o);
        end
        n_cmp++;
        if (pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1 || drain_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_status: got mask=%h ready=%b drain=%b, want mask=0 ready=1 drain=0",
                     pending_mask_o, mdu_ready_o, drain_req_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        m_clear();
        for (int k = 0; k < 4; k++) begin
            idle();
            n_cmp++;
            if (reg_write_en_o !== 1'b0 || pending_mask_o !== 32'd0) begin
                n_fail++;
                $display("FAIL midreset_nowrite%0d: got en=%b mask=%h, want en=0 mask=0",
                         k, reg_write_en_o, pending_mask_o);
            end
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_starvation();
        test_waw();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
